// File: rtl/alu_seq.sv
// alu_seq: two-state sequencer driving an external 10-bit ALU from a 4-entry register file
module alu_seq #(
    parameter int DW   = 10,
    parameter int NREG = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW+7:0] i_instr,
    output logic [DW-1:0] o_data,
    output logic [DW-1:0] o_arg0,
    output logic [DW-1:0] o_arg1,
    output logic [2:0]    o_oper,
    output logic          o_imm,
    input  logic [DW-1:0] i_result,
    input  logic [3:0]    i_flag,
    output logic [3:0]    o_flag,
    output logic          o_done,
    output logic          o_err,
    input  logic [1:0]    i_rsel,
    output logic [DW-1:0] o_rdata
);
    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;
    logic [DW-1:0] rf [NREG];
    logic [1:0] rd;
    always_comb begin
        state_nx = (state == IDLE && i_valid) ? EXEC : IDLE;
        o_ready  = state == IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            rd      <= '0;
            o_data  <= '0;
            o_arg0  <= '0;
            o_arg1  <= '0;
            o_oper  <= '0;
            o_imm   <= 1'b0;
            o_flag  <= '0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
        end else begin
            state   <= state_nx;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= rf[i_rsel];
            if (state == IDLE && i_valid) begin
                o_data <= i_instr[DW-1:0];
                o_arg0 <= rf[i_instr[1:0]];
                o_arg1 <= rf[i_instr[DW+1:DW]];
                rd     <= i_instr[DW+3:DW+2];
                o_imm  <= i_instr[DW+4];
                o_oper <= i_instr[DW+7:DW+5];
            end
            // opcode 7 is undefined: retire it without touching rf or flags
            if (state == EXEC) begin
                o_done <= 1'b1;
                if (o_oper == 3'd7) o_err <= 1'b1;
                else begin
                    rf[rd] <= i_result;
                    o_flag <= i_flag;
                end
            end
        end
    end
endmodule
